// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, entry type and helpers for the fetch front end
// Contents:
//   INST_BYTES     : bytes per instruction word (sequential PC step)
//   PKG_ADDR_W/_DATA_W : default address / instruction widths
//   fetch_entry_t  : one buffered instruction tagged with its PC
//   cnt_width()    : width of a counter that must hold 0..depth inclusive
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] pc;
    logic [PKG_DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush and occupancy count
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : empty the buffer (wins over push/pop)
//   push_i/_data_i: write one entry
//   pop_i         : consume the head entry
//   head_data_o   : head entry, read from registered storage (no fall-through)
//   count_o       : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_data_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: PC sequencing, credit-limited imem requests, tagged instruction buffer
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc   : restart fetch at redirect_pc (low two bits ignored)
//   imem_req_valid/_ready/_addr   : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data : in-order response channel, no back-pressure
//   inst_valid/_ready/_data/_pc   : buffered instruction to decode
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = PKG_ADDR_W,
  parameter int                DATA_W     = PKG_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int                CW      = cnt_width(FIFO_DEPTH);
  localparam int                EW      = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_BYTES);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [EW-1:0]     fifo_head;
  logic              req_hs, rsp_take, rsp_drop, fifo_push, fifo_pop;

  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  // Every slot that could still produce a FIFO write (live or doomed) holds a
  // credit, so a response always finds room and the memory is never stalled.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, drop_q} + {1'b0, fifo_count};
  assign imem_req_valid = ~rst & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_hs   = imem_req_valid & imem_req_ready;
  assign rsp_take = imem_rsp_valid & (drop_q == '0);
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_tgt;
      rsp_pc_d      = redirect_tgt;
      outstanding_d = '0;
      // Everything still owed by memory becomes garbage, including a request
      // accepted right now; a response arriving now is discarded and retires
      // one of those owed slots.
      drop_d = drop_q + outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
    end else begin
      if (req_hs)   fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_take) rsp_pc_d   = rsp_pc_q + PC_STEP;
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_take);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign fifo_push = rsp_take & ~redirect_valid;
  assign fifo_pop  = inst_valid & inst_ready;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i       (fifo_pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count)
  );

  assign inst_valid         = (fifo_count != '0);
  assign {inst_pc, inst_data} = fifo_head;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Memory side: each accepted request, tagged with the fetch epoch it belongs to.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  mreq_t       memq[$];
  ent_t        expq[$];
  int          epoch = 0;
  int          cyc   = 0;
  logic [31:0] exp_fetch;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Called at a falling edge: check outputs against the model, drive inputs for
  // the coming rising edge, then advance the model as that edge will.
  task automatic step(input int p_ready, input int p_iready, input int p_redir,
                      input logic [31:0] tgt, input int max_lat);
    logic  hs, pop, rsp_fire;
    mreq_t m;
    check("req_valid", imem_req_valid, (memq.size() + expq.size()) < DEPTH);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
    check("inst_valid", inst_valid, expq.size() != 0);
    if (inst_valid && expq.size() != 0) begin
      check("inst_pc", inst_pc, expq[0].pc);
      check("inst_data", inst_data, expq[0].data);
    end

    imem_req_ready = ($urandom_range(99) < p_ready);
    inst_ready     = ($urandom_range(99) < p_iready);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = tgt;
    rsp_fire       = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(3) != 0);
    imem_rsp_valid = rsp_fire;
    imem_rsp_data  = rsp_fire ? mem_word(memq[0].addr) : $urandom;

    hs  = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready;
    if (pop && expq.size() != 0) void'(expq.pop_front());
    if (rsp_fire) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !redirect_valid) expq.push_back('{m.pc, mem_word(m.pc)});
    end
    if (hs) memq.push_back('{imem_req_addr, exp_fetch, epoch, cyc + $urandom_range(max_lat, 1)});
    if (redirect_valid) begin
      epoch++;
      expq.delete();
      exp_fetch = tgt & ~32'h3;
    end else if (hs) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check({tag, "_inst_valid"}, inst_valid, 1'b0);
    check({tag, "_inst_data"}, inst_data, 32'h0);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] targets [4];

  initial begin
    rst = 1'b1;
    idle_inputs();
    exp_fetch = RESET_PC;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    release_reset();

    // Streaming, single-cycle latency, decode always ready.
    for (int i = 0; i < 150; i++) step(100, 100, 0, 32'h0, 1);

    // Decode stalled long enough to fill the buffer, then released.
    for (int i = 0; i < 30; i++) step(100, 0, 0, 32'h0, 2);
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_inst_valid", inst_valid, 1'b1);
    for (int i = 0; i < 40; i++) step(100, 100, 0, 32'h0, 2);

    // Directed redirect targets, including misaligned and near-wrap ones.
    targets[0] = 32'h0000_0100;
    targets[1] = 32'h0000_0102;
    targets[2] = 32'hFFFF_FFF0;
    targets[3] = 32'h0000_0020;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 6; i++) step(100, 30, 0, 32'h0, 3);
      step(100, 50, 100, targets[t], 3);
      for (int i = 0; i < 25; i++) step(100, 100, 0, 32'h0, 3);
    end

    // Fully random traffic with frequent (sometimes back-to-back) redirects.
    for (int i = 0; i < 2500; i++)
      step(70, 60, 8, ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : $urandom, 4);

    // Reset in the middle of traffic with work buffered and in flight.
    for (int i = 0; i < 8; i++) step(100, 0, 0, 32'h0, 4);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("midrst");
    memq.delete();
    expq.delete();
    epoch++;
    exp_fetch = RESET_PC;
    @(negedge clk);
    release_reset();
    check("post_rst_addr", imem_req_addr, RESET_PC);
    for (int i = 0; i < 300; i++) step(80, 70, 3, $urandom, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
